// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the execute stage and its helpers.
//   - icode constants (I_HALT .. I_POPQ)
//   - ALU function codes (A_ADD .. A_MUL) and condition codes (C_ALWAYS .. C_G)
//   - 2-bit status encodings (AOK/HLT/ADR/INS), register ID "none"
//   - bit positions of ZF/SF/OF inside the 3-bit CC vector {ZF,SF,OF}
//   - execute-stage FSM state type
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;
  localparam logic [3:0] A_MUL = 4'h4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // Status codes 1..4 keep only their low two bits, so INS folds onto 2'b00.
  localparam logic [1:0] STAT_AOK = 2'b01;
  localparam logic [1:0] STAT_HLT = 2'b10;
  localparam logic [1:0] STAT_ADR = 2'b11;
  localparam logic [1:0] STAT_INS = 2'b00;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } exec_state_e;

  function automatic logic is_cond_icode(input logic [3:0] icode);
    return (icode == I_JXX) || (icode == I_RRMOVQ);
  endfunction

endpackage

// File: rtl/exec_cond_eval.sv
// exec_cond_eval: combinational jXX/cmovXX condition evaluator.
// Ports:
//   cc       in  3  condition codes {ZF,SF,OF}
//   ifun     in  4  condition function code
//   cnd      out 1  condition holds (0 when ifun is invalid)
//   valid_fn out 1  ifun is a defined condition (0..6)
// Shared with the branch-predict checker, so it holds no state.
module exec_cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       valid_fn
);

  logic zf;
  logic sf;
  logic of;
  logic lt;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];
  assign lt = sf ^ of;

  always_comb begin
    cnd      = 1'b0;
    valid_fn = 1'b1;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  valid_fn = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_execute_stage.sv
// pipe_execute_stage: registered Y86-64 execute stage (E->M pipeline register).
// Computes valE, evaluates jXX/cmovXX conditions and owns the CC register.
// Optional feature macro: EXEC_MUL_EN adds an iterative shift-add mulq
// (OPq ifun 4); without it, ifun 4 is an invalid instruction.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             decode-side handshake
//   icode, ifun, val_a/b/c        instruction and operands
//   dst_e, dst_m, stat_in         destinations and incoming status
//   cc_hold                       downstream exception, blocks CC writes
//   out_valid/out_ready           memory-side handshake
//   out_icode .. out_stat         registered E->M fields
//   cc_out                        current CC register {ZF,SF,OF}
module pipe_execute_stage #(
  parameter int         DATA_W     = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [3:0] REG_NONE   = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] val_a,
  input  logic [DATA_W-1:0] val_b,
  input  logic [DATA_W-1:0] val_c,
  input  logic [3:0]        dst_e,
  input  logic [3:0]        dst_m,
  input  logic [1:0]        stat_in,
  input  logic              cc_hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_val_e,
  output logic [DATA_W-1:0] out_val_a,
  output logic              out_cnd,
  output logic [3:0]        out_dst_e,
  output logic [3:0]        out_dst_m,
  output logic [1:0]        out_stat,
  output logic [2:0]        cc_out
);
  import y86_pkg::*;

  localparam int               MSB  = DATA_W - 1;
  localparam logic [MSB:0]     STEP = DATA_W'(STACK_STEP);

  exec_state_e state_reg;
  exec_state_e state_next;

  logic         xfer;
  logic         start_mul;
  logic         mul_done;
  logic         load_direct;
  logic [MSB:0] alu_res;
  logic         alu_of;
  logic         alu_ok;
  logic [MSB:0] val_e_calc;
  logic         cond_cnd;
  logic         cond_valid;
  logic         local_ins;
  logic [1:0]   stat_calc;
  logic         cnd_calc;
  logic [3:0]   dst_e_calc;
  logic [3:0]   dst_m_calc;
  logic         cc_we;
  logic [2:0]   cc_next;
  logic [2:0]   cc_reg;

  logic         out_valid_reg;
  logic [3:0]   out_icode_reg;
  logic [MSB:0] out_val_e_reg;
  logic [MSB:0] out_val_a_reg;
  logic         out_cnd_reg;
  logic [3:0]   out_dst_e_reg;
  logic [3:0]   out_dst_m_reg;
  logic [1:0]   out_stat_reg;

  // Conditions always see the CC value from before this cycle's update.
  exec_cond_eval u_cond (
    .cc       (cc_reg),
    .ifun     (ifun),
    .cnd      (cond_cnd),
    .valid_fn (cond_valid)
  );

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_ok  = 1'b1;
    case (ifun)
      A_ADD: begin
        alu_res = val_b + val_a;
        alu_of  = (val_a[MSB] == val_b[MSB]) && (alu_res[MSB] != val_a[MSB]);
      end
      A_SUB: begin
        alu_res = val_b - val_a;
        alu_of  = (val_a[MSB] != val_b[MSB]) && (alu_res[MSB] != val_b[MSB]);
      end
      A_AND: alu_res = val_b & val_a;
      A_XOR: alu_res = val_b ^ val_a;
`ifdef EXEC_MUL_EN
      A_MUL: alu_res = '0;  // product comes from the iterative unit
`endif
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    val_e_calc = '0;
    case (icode)
      I_IRMOVQ:           val_e_calc = val_c;
      I_RMMOVQ, I_MRMOVQ: val_e_calc = val_b + val_c;
      I_OPQ:              val_e_calc = alu_res;
      I_RRMOVQ:           val_e_calc = val_a;
      I_PUSHQ, I_CALL:    val_e_calc = val_b - STEP;
      I_POPQ, I_RET:      val_e_calc = val_b + STEP;
      default:            val_e_calc = '0;
    endcase
  end

  assign local_ins = (icode > I_POPQ)
                   || ((icode == I_OPQ) && !alu_ok)
                   || (is_cond_icode(icode) && !cond_valid);

  // An upstream fault outranks anything detected here.
  always_comb begin
    if (stat_in != STAT_AOK)     stat_calc = stat_in;
    else if (local_ins)          stat_calc = STAT_INS;
    else if (icode == I_HALT)    stat_calc = STAT_HLT;
    else                         stat_calc = STAT_AOK;
  end

  assign cnd_calc   = !local_ins && is_cond_icode(icode) && cond_cnd;
  assign dst_e_calc = (local_ins || ((icode == I_RRMOVQ) && !cond_cnd)) ? REG_NONE : dst_e;
  assign dst_m_calc = local_ins ? REG_NONE : dst_m;

  // Handshake and FSM
  assign xfer        = in_valid && in_ready;
  assign load_direct = xfer && !start_mul;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_mul) state_next = ST_BUSY;
      ST_BUSY: if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  end

  assign cc_we   = load_direct && (icode == I_OPQ) && !local_ins
                && (stat_in == STAT_AOK) && !cc_hold;
  assign cc_next = {(val_e_calc == '0), val_e_calc[MSB], alu_of};

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);

  logic [MSB:0]     mcand_reg;
  logic [MSB:0]     mplier_reg;
  logic [MSB:0]     acc_reg;
  logic [MSB:0]     acc_step;
  logic [CNT_W-1:0] cnt_reg;
  logic [MSB:0]     pend_val_a_reg;
  logic [3:0]       pend_dst_e_reg;
  logic [3:0]       pend_dst_m_reg;
  logic [1:0]       pend_stat_reg;
  logic             pend_cc_ok_reg;
  logic             mul_cc_we;

  assign start_mul = xfer && (icode == I_OPQ) && (ifun == A_MUL);
  assign mul_done  = (state_reg == ST_BUSY) && (cnt_reg == CNT_W'(DATA_W - 1));
  assign acc_step  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign mul_cc_we = mul_done && pend_cc_ok_reg && !cc_hold;

  // One multiplier bit per BUSY cycle; the last step's sum is the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      pend_val_a_reg <= '0;
      pend_dst_e_reg <= REG_NONE;
      pend_dst_m_reg <= REG_NONE;
      pend_stat_reg  <= STAT_AOK;
      pend_cc_ok_reg <= 1'b0;
    end else if (start_mul) begin
      mcand_reg      <= val_b;
      mplier_reg     <= val_a;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      pend_val_a_reg <= val_a;
      pend_dst_e_reg <= dst_e_calc;
      pend_dst_m_reg <= dst_m_calc;
      pend_stat_reg  <= stat_calc;
      pend_cc_ok_reg <= (stat_in == STAT_AOK);
    end else if (state_reg == ST_BUSY) begin
      acc_reg    <= acc_step;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_reg <= 3'b100;
    end else if (cc_we) begin
      cc_reg <= cc_next;
`ifdef EXEC_MUL_EN
    end else if (mul_cc_we) begin
      cc_reg <= {(acc_step == '0), acc_step[MSB], 1'b0};
`endif
    end
  end

  // E->M register. On a mulq accept nothing is loaded, but a draining entry
  // still leaves, so the register is empty when the product arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_icode_reg <= I_NOP;
      out_val_e_reg <= '0;
      out_val_a_reg <= '0;
      out_cnd_reg   <= 1'b0;
      out_dst_e_reg <= REG_NONE;
      out_dst_m_reg <= REG_NONE;
      out_stat_reg  <= STAT_AOK;
    end else if (load_direct) begin
      out_valid_reg <= 1'b1;
      out_icode_reg <= icode;
      out_val_e_reg <= val_e_calc;
      out_val_a_reg <= val_a;
      out_cnd_reg   <= cnd_calc;
      out_dst_e_reg <= dst_e_calc;
      out_dst_m_reg <= dst_m_calc;
      out_stat_reg  <= stat_calc;
`ifdef EXEC_MUL_EN
    end else if (mul_done) begin
      out_valid_reg <= 1'b1;
      out_icode_reg <= I_OPQ;
      out_val_e_reg <= acc_step;
      out_val_a_reg <= pend_val_a_reg;
      out_cnd_reg   <= 1'b0;
      out_dst_e_reg <= pend_dst_e_reg;
      out_dst_m_reg <= pend_dst_m_reg;
      out_stat_reg  <= pend_stat_reg;
`endif
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_icode = out_icode_reg;
  assign out_val_e = out_val_e_reg;
  assign out_val_a = out_val_a_reg;
  assign out_cnd   = out_cnd_reg;
  assign out_dst_e = out_dst_e_reg;
  assign out_dst_m = out_dst_m_reg;
  assign out_stat  = out_stat_reg;
  assign cc_out    = cc_reg;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// tb_pipe_execute_stage: directed scenarios plus a randomized run scored
// against a Y86-64 instruction-level reference model.
module tb_pipe_execute_stage;

  localparam int DATA_W = 64;

  localparam logic [1:0] S_AOK = 2'b01;
  localparam logic [1:0] S_HLT = 2'b10;
  localparam logic [1:0] S_ADR = 2'b11;
  localparam logic [1:0] S_INS = 2'b00;
  localparam logic [3:0] RNONE = 4'hF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        icode = 4'h1;
  logic [3:0]        ifun = 4'h0;
  logic [DATA_W-1:0] val_a = '0;
  logic [DATA_W-1:0] val_b = '0;
  logic [DATA_W-1:0] val_c = '0;
  logic [3:0]        dst_e = 4'hF;
  logic [3:0]        dst_m = 4'hF;
  logic [1:0]        stat_in = 2'b01;
  logic              cc_hold = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [3:0]        out_icode;
  logic [DATA_W-1:0] out_val_e;
  logic [DATA_W-1:0] out_val_a;
  logic              out_cnd;
  logic [3:0]        out_dst_e;
  logic [3:0]        out_dst_m;
  logic [1:0]        out_stat;
  logic [2:0]        cc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_execute_stage #(.DATA_W(DATA_W), .STACK_STEP(8), .REG_NONE(4'hF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .val_a(val_a), .val_b(val_b), .val_c(val_c),
    .dst_e(dst_e), .dst_m(dst_m), .stat_in(stat_in), .cc_hold(cc_hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_val_e(out_val_e), .out_val_a(out_val_a), .out_cnd(out_cnd),
    .out_dst_e(out_dst_e), .out_dst_m(out_dst_m), .out_stat(out_stat),
    .cc_out(cc_out)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic        cnd;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  stat;
    logic        bad;
    logic        cc_wr;
    logic [2:0]  cc_new;
  } exp_t;

  // Instruction-level reference: what the ISA says one instruction does.
  function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [3:0] de,
                                 input logic [3:0] dm, input logic [1:0] st,
                                 input logic hold, input logic [2:0] cc);
    exp_t r;
    logic bad, take, of, zf, sf, lt;
    logic [63:0] e;
    logic signed [65:0] s;
    zf = cc[2]; sf = cc[1]; lt = cc[1] ^ cc[0];
    bad = (ic > 4'd11); take = 1'b0; of = 1'b0; e = 64'd0; s = '0;
    case (ic)
      4'd3: e = c;
      4'd4, 4'd5: e = b + c;
      4'd2: e = a;
      4'd8, 4'd10: e = b - 64'd8;
      4'd9, 4'd11: e = b + 64'd8;
      4'd6: begin
        case (fn)
          4'd0: begin
            e = b + a;
            s = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
            of = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < 66'sh3_8000_0000_0000_0000);
          end
          4'd1: begin
            e = b - a;
            s = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
            of = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < 66'sh3_8000_0000_0000_0000);
          end
          4'd2: e = b & a;
          4'd3: e = b ^ a;
          default: bad = 1'b1;
        endcase
      end
      default: e = 64'd0;
    endcase
    if (ic == 4'd2 || ic == 4'd7) begin
      case (fn)
        4'd0: take = 1'b1;
        4'd1: take = lt || zf;
        4'd2: take = lt;
        4'd3: take = zf;
        4'd4: take = !zf;
        4'd5: take = !lt;
        4'd6: take = !lt && !zf;
        default: bad = 1'b1;
      endcase
    end
    r.icode  = ic;
    r.val_e  = e;
    r.val_a  = a;
    r.bad    = bad;
    r.cnd    = !bad && (ic == 4'd2 || ic == 4'd7) && take;
    r.dst_e  = (bad || (ic == 4'd2 && !take)) ? RNONE : de;
    r.dst_m  = bad ? RNONE : dm;
    r.stat   = (st != S_AOK) ? st : bad ? S_INS : (ic == 4'd0) ? S_HLT : S_AOK;
    r.cc_wr  = (ic == 4'd6) && !bad && (st == S_AOK) && !hold;
    r.cc_new = {(e == 64'd0), e[63], of};
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 16));
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Presents one instruction and returns #1 after the edge it was accepted on.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                      input logic [3:0] dm, input logic [1:0] st, input logic hold);
    int waited;
    waited = 0;
    icode = ic; ifun = fn; val_a = a; val_b = b; val_c = c;
    dst_e = de; dst_m = dm; stat_in = st; cc_hold = hold; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cc_hold = 1'b0; stat_in = S_AOK;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; icode = 4'h6; val_a = 64'd3; val_b = 64'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (cc_out !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b want 100", cc_out); end
    checks++; if (out_val_e !== 64'd0 || out_val_a !== 64'd0) begin errors++; $display("FAIL reset_vals: got e=%h a=%h want 0", out_val_e, out_val_a); end
    checks++; if (out_dst_e !== RNONE || out_dst_m !== RNONE) begin errors++; $display("FAIL reset_dst: got %h/%h want f/f", out_dst_e, out_dst_m); end
    checks++; if (out_stat !== S_AOK || out_icode !== 4'h1 || out_cnd !== 1'b0) begin errors++; $display("FAIL reset_misc: got stat=%b icode=%h cnd=%b want 01/1/0", out_stat, out_icode, out_cnd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    $display("reset: cc=%b out_valid=%0b", cc_out, out_valid);
  endtask

  task automatic test_sub_zero();
    out_ready = 1'b1;
    send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, RNONE, S_AOK, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_val_e !== 64'd0) begin errors++; $display("FAIL sub_zero: got valid=%0b e=%h want 1/0", out_valid, out_val_e); end
    checks++; if (cc_out !== 3'b100 || out_stat !== S_AOK || out_dst_e !== 4'h2) begin errors++; $display("FAIL sub_zero_cc: got cc=%b stat=%b dst=%h want 100/01/2", cc_out, out_stat, out_dst_e); end
    $display("subq 5-5: e=%h cc=%b", out_val_e, cc_out);
  endtask

  task automatic test_add_overflow();
    send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3, RNONE, S_AOK, 1'b0);
    checks++; if (out_val_e !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_ovf_val: got %h want 8000000000000000", out_val_e); end
    checks++; if (cc_out !== 3'b011) begin errors++; $display("FAIL add_ovf_cc: got %b want 011", cc_out); end
    $display("addq max+1: e=%h cc=%b", out_val_e, cc_out);
  endtask

  task automatic test_cond();
    send(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h4, RNONE, S_AOK, 1'b0);
    checks++; if (cc_out !== 3'b010 || out_val_e !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL cond_setup: got cc=%b e=%h want 010/fffffffffffffffe", cc_out, out_val_e); end
    send(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, RNONE, RNONE, S_AOK, 1'b0);
    checks++; if (out_cnd !== 1'b1 || out_val_e !== 64'd0) begin errors++; $display("FAIL jle: got cnd=%0b e=%h want 1/0", out_cnd, out_val_e); end
    send(4'h2, 4'h6, 64'h55, 64'd0, 64'd0, 4'h3, RNONE, S_AOK, 1'b0);
    checks++; if (out_dst_e !== RNONE || out_cnd !== 1'b0 || out_val_e !== 64'h55) begin errors++; $display("FAIL cmovg: got dst=%h cnd=%0b e=%h want f/0/55", out_dst_e, out_cnd, out_val_e); end
    send(4'h2, 4'h2, 64'h66, 64'd0, 64'd0, 4'h3, RNONE, S_AOK, 1'b0);
    checks++; if (out_dst_e !== 4'h3 || out_cnd !== 1'b1) begin errors++; $display("FAIL cmovl: got dst=%h cnd=%0b want 3/1", out_dst_e, out_cnd); end
    $display("cond: cc=%b cmovl dst=%h", cc_out, out_dst_e);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'h3, 4'h0, 64'd0, 64'd0, 64'h11, 4'h1, RNONE, S_AOK, 1'b0);
    icode = 4'h3; ifun = 4'h0; val_c = 64'h22; dst_e = 4'h5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_val_e !== 64'h11) begin errors++; $display("FAIL stall_hold%0d: got ready=%0b valid=%0b e=%h want 0/1/11", i, in_ready, out_valid, out_val_e); end
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_resume: got ready=%0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_val_e !== 64'h22 || out_dst_e !== 4'h5) begin errors++; $display("FAIL stall_second: got valid=%0b e=%h dst=%h want 1/22/5", out_valid, out_val_e, out_dst_e); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got valid=%0b want 0", out_valid); end
    $display("back_to_back: delivered 11 then 22");
  endtask

  task automatic test_misc();
    send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, RNONE, S_AOK, 1'b0);
    checks++; if (out_val_e !== 64'hF8 || out_dst_e !== 4'h4) begin errors++; $display("FAIL pushq: got e=%h dst=%h want f8/4", out_val_e, out_dst_e); end
    send(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 4'h1, 4'h2, S_AOK, 1'b0);
    checks++; if (out_stat !== S_INS || cc_out !== 3'b010 || out_dst_e !== RNONE || out_dst_m !== RNONE) begin errors++; $display("FAIL bad_icode: got stat=%b cc=%b dst=%h/%h want 00/010/f/f", out_stat, cc_out, out_dst_e, out_dst_m); end
    send(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h1, RNONE, S_AOK, 1'b1);
    checks++; if (out_val_e !== 64'd2 || cc_out !== 3'b010) begin errors++; $display("FAIL cc_hold: got e=%h cc=%b want 2/010", out_val_e, cc_out); end
    send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, RNONE, S_ADR, 1'b0);
    checks++; if (out_stat !== S_ADR || cc_out !== 3'b010) begin errors++; $display("FAIL stat_pass: got stat=%b cc=%b want 11/010", out_stat, cc_out); end
    send(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, RNONE, RNONE, S_AOK, 1'b0);
    checks++; if (out_stat !== S_HLT || out_val_e !== 64'd0) begin errors++; $display("FAIL halt: got stat=%b e=%h want 10/0", out_stat, out_val_e); end
`ifndef EXEC_MUL_EN
    send(4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 4'h1, RNONE, S_AOK, 1'b0);
    checks++; if (out_stat !== S_INS || cc_out !== 3'b010 || out_dst_e !== RNONE) begin errors++; $display("FAIL mul_disabled: got stat=%b cc=%b dst=%h want 00/010/f", out_stat, cc_out, out_dst_e); end
`endif
    $display("misc: cc=%b stat=%b", cc_out, out_stat);
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    exp_t f;
    logic [2:0] mcc;
    logic [3:0] fn;
    logic [3:0] ic;
    int sent;
    sent = 0;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mcc = 3'b100;
    for (int cyc = 0; cyc < 800; cyc++) begin
      ic = 4'($urandom_range(0, 13));
      if (ic == 4'd2 || ic == 4'd7) fn = 4'($urandom_range(0, 7));
      else if (ic == 4'd6) begin fn = 4'($urandom_range(0, 4)); if (fn == 4'd4) fn = 4'd5; end
      else fn = 4'd0;
      icode = ic; ifun = fn; val_a = rand64(); val_b = rand64(); val_c = rand64();
      dst_e = 4'($urandom_range(0, 15)); dst_m = 4'($urandom_range(0, 15));
      stat_in = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : S_AOK;
      cc_hold = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (cc_out !== mcc) begin errors++; $display("FAIL rnd_cc cyc%0d: got %b want %b", cyc, cc_out, mcc); end
      checks++; if (out_valid !== (q.size() != 0) || in_ready !== ((q.size() == 0) || out_ready)) begin
        errors++; $display("FAIL rnd_hs cyc%0d: got valid=%0b ready=%0b want valid=%0b ready=%0b", cyc, out_valid, in_ready, q.size() != 0, (q.size() == 0) || out_ready);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        f = q.pop_front();
        checks++;
        if (out_icode !== f.icode || (!f.bad && out_val_e !== f.val_e) || out_val_a !== f.val_a ||
            out_cnd !== f.cnd || out_dst_e !== f.dst_e || out_dst_m !== f.dst_m || out_stat !== f.stat) begin
          errors++;
          $display("FAIL rnd_out cyc%0d: got ic=%h e=%h a=%h c=%b de=%h dm=%h st=%b want ic=%h e=%h a=%h c=%b de=%h dm=%h st=%b",
                   cyc, out_icode, out_val_e, out_val_a, out_cnd, out_dst_e, out_dst_m, out_stat,
                   f.icode, f.val_e, f.val_a, f.cnd, f.dst_e, f.dst_m, f.stat);
        end
      end
      e = '0;
      if (in_valid && in_ready) begin
        e = model(ic, fn, val_a, val_b, val_c, dst_e, dst_m, stat_in, cc_hold, mcc);
        q.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      if (e.cc_wr) mcc = e.cc_new;
    end
    in_valid = 1'b0; cc_hold = 1'b0; stat_in = S_AOK; out_ready = 1'b1;
    @(posedge clk); #1;
    $display("random: %0d instructions accepted", sent);
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    int edges;
    out_ready = 1'b1;
    send(4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 4'h2, RNONE, S_AOK, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy: got ready=%0b valid=%0b want 0/0", in_ready, out_valid); end
    edges = 0;
    while (!out_valid && edges < 300) begin @(posedge clk); #1; edges++; end
    checks++; if (edges != DATA_W) begin errors++; $display("FAIL mul_latency: got %0d edges want %0d", edges, DATA_W); end
    checks++; if (out_val_e !== 64'd42 || cc_out !== 3'b000 || out_dst_e !== 4'h2) begin errors++; $display("FAIL mul_result: got e=%h cc=%b dst=%h want 2a/000/2", out_val_e, cc_out, out_dst_e); end
    send(4'h6, 4'h4, 64'd3, 64'd3, 64'd0, 4'h2, RNONE, S_AOK, 1'b0);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cc_out !== 3'b100) begin errors++; $display("FAIL mul_reset: got valid=%0b ready=%0b cc=%b want 0/1/100", out_valid, in_ready, cc_out); end
    repeat (DATA_W + 4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_discard: got valid=%0b want 0", out_valid); end
    $display("mulq 7*6: latency=%0d", edges);
  endtask
`endif

  initial begin
    test_reset();
    test_sub_zero();
    test_add_overflow();
    test_cond();
    test_back_to_back();
    test_misc();
    test_random();
`ifdef EXEC_MUL_EN
    test_mul();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
